// File: rtl/disp_pkg.sv
// Shared parameters, pixel/word layout and Gray-code helpers for the display pixel buffer.
package disp_pkg;

  localparam int unsigned DEPTH_LOG2  = 9;
  localparam int unsigned BURST_WORDS = 32;
  localparam int unsigned WORD_W      = 64;
  localparam int unsigned CH_W        = 8;

  // xRGB pixel: R at [23:16], G at [15:8], B at [7:0]; top byte ignored
  typedef struct packed {
    logic [CH_W-1:0] x;
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pixel_t;

  // One AXI beat carries two pixels, the low half is shown first
  typedef struct packed {
    pixel_t hi;
    pixel_t lo;
  } word_t;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/disp_if.sv
// AXI read-data capture and display-side signals of the pixel buffer.
interface disp_if;
  import disp_pkg::*;

  logic [WORD_W-1:0] RDATA;
  logic              RVALID;
  logic              RREADY;
  logic              DISPON;
  logic              BUF_WREADY;
  logic              BUF_OVERFLOW;
  logic              DSP_preDE;
  logic [CH_W-1:0]   DSP_R;
  logic [CH_W-1:0]   DSP_G;
  logic [CH_W-1:0]   DSP_B;
  logic              DSP_DE;
  logic              BUF_UNDERFLOW;

  modport master (
    output RDATA, RVALID, RREADY, DISPON, DSP_preDE,
    input  BUF_WREADY, BUF_OVERFLOW, DSP_R, DSP_G, DSP_B, DSP_DE, BUF_UNDERFLOW
  );

  modport slave (
    input  RDATA, RVALID, RREADY, DISPON, DSP_preDE,
    output BUF_WREADY, BUF_OVERFLOW, DSP_R, DSP_G, DSP_B, DSP_DE, BUF_UNDERFLOW
  );

endinterface

// File: rtl/disp_fifo_async.sv
// Dual-clock FIFO: Gray pointers with 2-FF syncs, RAM written on wclk, head word
// presented registered on rclk so a pop can consume it in the same cycle.
module disp_fifo_async #(
  parameter int unsigned AW = disp_pkg::DEPTH_LOG2,
  parameter int unsigned DW = disp_pkg::WORD_W
) (
  input  logic          i_wclk,
  input  logic          i_wrst,
  input  logic          i_wen,
  input  logic [DW-1:0] i_wdata,
  output logic          o_full_c,
  output logic [AW:0]   o_used_c,
  input  logic          i_rclk,
  input  logic          i_rrst,
  input  logic          i_ren,
  output logic [DW-1:0] o_rdata,
  output logic          o_empty_c
);
  import disp_pkg::*;

  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  logic [PW-1:0] r_wptr_bin, r_wptr_gray, r_rptr_gray_s1, r_rptr_gray_s2;
  logic [PW-1:0] r_rptr_bin, r_rptr_gray, r_wptr_gray_s1, r_wptr_gray_s2;
  logic [PW-1:0] w_rptr_sync_bin, w_used, w_wptr_next, w_rptr_next;
  logic          w_full, w_wr, w_empty, w_rd;
  logic [DW-1:0] r_rdata;

  // Write side: occupancy against the lagging synced read pointer
  assign w_rptr_sync_bin = PW'(gray2bin(32'(r_rptr_gray_s2)));
  assign w_used          = r_wptr_bin - w_rptr_sync_bin;
  assign w_full          = (w_used == PW'(DEPTH));
  assign w_wr            = i_wen & ~w_full;
  assign w_wptr_next     = r_wptr_bin + PW'(w_wr);

  always_ff @(posedge i_wclk) begin
    if (i_wrst) begin
      r_wptr_bin     <= '0;
      r_wptr_gray    <= '0;
      r_rptr_gray_s1 <= '0;
      r_rptr_gray_s2 <= '0;
    end else begin
      r_wptr_bin     <= w_wptr_next;
      r_wptr_gray    <= PW'(bin2gray(32'(w_wptr_next)));
      r_rptr_gray_s1 <= r_rptr_gray;
      r_rptr_gray_s2 <= r_rptr_gray_s1;
    end
  end

  always_ff @(posedge i_wclk) begin
    if (w_wr) begin
      r_mem[r_wptr_bin[AW-1:0]] <= i_wdata;
    end
  end

  // Read side: Gray equality against the synced write pointer means empty
  assign w_empty     = (r_rptr_gray == r_wptr_gray_s2);
  assign w_rd        = i_ren & ~w_empty;
  assign w_rptr_next = r_rptr_bin + PW'(w_rd);

  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_rptr_bin     <= '0;
      r_rptr_gray    <= '0;
      r_wptr_gray_s1 <= '0;
      r_wptr_gray_s2 <= '0;
    end else begin
      r_rptr_bin     <= w_rptr_next;
      r_rptr_gray    <= PW'(bin2gray(32'(w_rptr_next)));
      r_wptr_gray_s1 <= r_wptr_gray;
      r_wptr_gray_s2 <= r_wptr_gray_s1;
    end
  end

  // Read at the post-pop address so r_rdata always holds the current head
  always_ff @(posedge i_rclk) begin
    r_rdata <= r_mem[w_rptr_next[AW-1:0]];
  end

  assign o_full_c  = w_full;
  assign o_used_c  = w_used;
  assign o_empty_c = w_empty;
  assign o_rdata   = r_rdata;

endmodule

// File: rtl/disp_buffer.sv
// Pixel buffer: captures AXI read beats into a dual-clock FIFO and unpacks each
// 64-bit word into two xRGB pixels paced by the display enable.
module disp_buffer #(
  parameter int unsigned DEPTH_LOG2  = disp_pkg::DEPTH_LOG2,
  parameter int unsigned BURST_WORDS = disp_pkg::BURST_WORDS
) (
  input  logic ACLK,
  input  logic ARST,
  input  logic PCK,
  input  logic PRST,
  disp_if.slave bus
);
  import disp_pkg::*;

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] WREADY_MAX = PW'(DEPTH - BURST_WORDS);

  logic          w_wen, w_full_c, w_empty_c, w_pop;
  logic [PW-1:0] w_used_c;
  word_t         w_head;

  logic r_wready, r_overflow;

  logic      r_dispon_s1, r_dispon_s2;
  phase_e    r_phase, w_phase_nxt;
  pixel_t    r_hold, w_hold_nxt, w_pix_nxt;
  logic [CH_W-1:0] r_dsp_r, r_dsp_g, r_dsp_b;
  logic      r_dsp_de, w_de_nxt;
  logic      r_underflow, w_unf_nxt;
  logic      w_unused_x;

  assign w_wen = bus.RVALID & bus.RREADY;

  disp_fifo_async #(
    .AW (DEPTH_LOG2),
    .DW (WORD_W)
  ) u_fifo (
    .i_wclk    (ACLK),
    .i_wrst    (ARST),
    .i_wen     (w_wen),
    .i_wdata   (bus.RDATA),
    .o_full_c  (w_full_c),
    .o_used_c  (w_used_c),
    .i_rclk    (PCK),
    .i_rrst    (PRST),
    .i_ren     (w_pop),
    .o_rdata   (w_head),
    .o_empty_c (w_empty_c)
  );

  // Ready for another burst only while a whole burst of space is guaranteed
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_wready   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wready <= (w_used_c <= WREADY_MAX);
      if (w_wen && w_full_c) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Pixel pair unpacking; phase survives blanking so pairs stay aligned
  always_comb begin
    w_phase_nxt = r_phase;
    w_hold_nxt  = r_hold;
    w_pix_nxt   = '0;
    w_de_nxt    = bus.DSP_preDE;
    w_unf_nxt   = r_underflow;
    w_pop       = 1'b0;
    if (bus.DSP_preDE && r_dispon_s2) begin
      case (r_phase)
        PH_LO: begin
          if (!w_empty_c) begin
            w_pop       = 1'b1;
            w_pix_nxt   = w_head.lo;
            w_hold_nxt  = w_head.hi;
            w_phase_nxt = PH_HI;
          end else begin
            w_unf_nxt = 1'b1;
          end
        end
        PH_HI: begin
          w_pix_nxt   = r_hold;
          w_phase_nxt = PH_LO;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCK) begin
    if (PRST) begin
      r_dispon_s1 <= 1'b0;
      r_dispon_s2 <= 1'b0;
      r_phase     <= PH_LO;
      r_hold      <= '0;
      r_dsp_r     <= '0;
      r_dsp_g     <= '0;
      r_dsp_b     <= '0;
      r_dsp_de    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_dispon_s1 <= bus.DISPON;
      r_dispon_s2 <= r_dispon_s1;
      r_phase     <= w_phase_nxt;
      r_hold      <= w_hold_nxt;
      r_dsp_r     <= w_pix_nxt.r;
      r_dsp_g     <= w_pix_nxt.g;
      r_dsp_b     <= w_pix_nxt.b;
      r_dsp_de    <= w_de_nxt;
      r_underflow <= w_unf_nxt;
    end
  end

  assign w_unused_x = ^{w_head.lo.x, w_head.hi.x, w_pix_nxt.x, r_hold.x};

  assign bus.BUF_WREADY    = r_wready;
  assign bus.BUF_OVERFLOW  = r_overflow;
  assign bus.DSP_R         = r_dsp_r;
  assign bus.DSP_G         = r_dsp_g;
  assign bus.DSP_B         = r_dsp_b;
  assign bus.DSP_DE        = r_dsp_de;
  assign bus.BUF_UNDERFLOW = r_underflow;

endmodule

// File: tb/tb_disp_buffer.sv
// Self-checking bench for disp_buffer: vector tables for short sequences and a
// pixel-sequence scoreboard for burst/overflow/streaming traffic.
module tb_disp_buffer;
  import disp_pkg::*;

  logic ACLK = 1'b0;
  logic PCK  = 1'b0;
  logic ARST = 1'b1;
  logic PRST = 1'b1;
  int   a_half = 5;
  int   p_half = 7;

  disp_if bus();

  disp_buffer u_dut (
    .ACLK (ACLK),
    .ARST (ARST),
    .PCK  (PCK),
    .PRST (PRST),
    .bus  (bus)
  );

  initial forever #(a_half) ACLK = ~ACLK;
  initial forever #(p_half) PCK  = ~PCK;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];
  int words_sent = 0;

  typedef struct {
    logic        pre_de;
    logic        exp_de;
    logic [23:0] exp_rgb;
    logic        exp_unf;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Word w holds pixels 2w (low) and 2w+1 (high); top byte is filler
  function automatic logic [63:0] mkword(input int w);
    logic [31:0] lo, hi;
    lo = {8'(w * 3), 24'(2 * w)};
    hi = {8'(w * 5 + 1), 24'(2 * w + 1)};
    return {hi, lo};
  endfunction

  function automatic logic [23:0] rgb();
    return {bus.DSP_R, bus.DSP_G, bus.DSP_B};
  endfunction

  task automatic add_vec(input logic p, input logic d, input logic [23:0] c, input logic u);
    vec_t v;
    v.pre_de = p; v.exp_de = d; v.exp_rgb = c; v.exp_unf = u;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    bus.RVALID = 1'b0; bus.RREADY = 1'b0; bus.DSP_preDE = 1'b0; bus.RDATA = '0;
    ARST = 1'b1; PRST = 1'b1;
    repeat (4) @(posedge ACLK);
    repeat (4) @(posedge PCK);
    #1;
    chk("rst.wready_in_reset", bus.BUF_WREADY, 0);
    chk("rst.ovf", bus.BUF_OVERFLOW, 0);
    chk("rst.de", bus.DSP_DE, 0);
    chk("rst.rgb", rgb(), 0);
    chk("rst.unf", bus.BUF_UNDERFLOW, 0);
    fork
      begin @(negedge ACLK); ARST = 1'b0; end
      begin @(negedge PCK);  PRST = 1'b0; end
    join
    for (int k = 0; k < 3; k++) begin
      @(posedge ACLK); #1;
      if (bus.BUF_WREADY) break;
    end
    chk("rst.wready_after", bus.BUF_WREADY, 1);
    exp_q.delete();
    words_sent = 0;
    repeat (4) @(negedge PCK);
  endtask

  task automatic send_word(input logic [63:0] d, input bit rnd, input bit track);
    if (rnd) begin
      while ($urandom_range(0, 3) == 0) begin
        @(negedge ACLK);
        bus.RDATA = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) begin bus.RVALID = 1'b1; bus.RREADY = 1'b0; end
        else begin bus.RVALID = 1'b0; bus.RREADY = 1'b1; end
      end
    end
    @(negedge ACLK);
    bus.RDATA = d; bus.RVALID = 1'b1; bus.RREADY = 1'b1;
    if (track) begin
      exp_q.push_back(d[23:0]);
      exp_q.push_back(d[55:32]);
      words_sent++;
    end
  endtask

  task automatic end_write();
    @(negedge ACLK);
    bus.RVALID = 1'b0; bus.RREADY = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge PCK);
      bus.DSP_preDE = vecs[i].pre_de;
      @(posedge PCK); #1;
      chk($sformatf("%s.de%0d", tag, i), bus.DSP_DE, vecs[i].exp_de);
      chk($sformatf("%s.rgb%0d", tag, i), rgb(), vecs[i].exp_rgb);
      chk($sformatf("%s.unf%0d", tag, i), bus.BUF_UNDERFLOW, vecs[i].exp_unf);
    end
    @(negedge PCK);
    bus.DSP_preDE = 1'b0;
    vecs.delete();
  endtask

  // Drive preDE hi/lo pattern; each shown pixel must be the next one written
  task automatic read_pixels(input int npix, input int hi, input int lo, input int max_cyc, input string tag);
    int got = 0;
    int cyc = 0;
    logic cur;
    logic [23:0] e;
    while (got < npix && cyc < max_cyc) begin
      @(negedge PCK);
      cur = ((cyc % (hi + lo)) < hi);
      bus.DSP_preDE = cur;
      @(posedge PCK); #1;
      chk($sformatf("%s.de%0d", tag, cyc), bus.DSP_DE, cur);
      if (cur) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'h0;
        chk($sformatf("%s.pix%0d", tag, got), rgb(), e);
        got++;
      end else begin
        chk($sformatf("%s.blank%0d", tag, cyc), rgb(), 0);
      end
      cyc++;
    end
    @(negedge PCK);
    bus.DSP_preDE = 1'b0;
    chk($sformatf("%s.count", tag), got, npix);
  endtask

  task automatic stream(input int ah, input int ph, input bit gaps, input string tag);
    a_half = ah; p_half = ph;
    do_reset();
    fork
      begin : writer
        int w = 0;
        while (w < 1200) begin
          int wc = 0;
          while (!bus.BUF_WREADY && wc < 5000) begin @(negedge ACLK); wc++; end
          if (!bus.BUF_WREADY) begin
            chk({tag, ".wready_timeout"}, 0, 1);
            break;
          end
          for (int b = 0; b < 32 && w < 1200; b++) begin
            send_word(mkword(w), gaps, 1'b1);
            w++;
          end
          end_write();
        end
      end
      begin : reader
        int t = 0;
        while (words_sent < 256 && t < 20000) begin @(negedge PCK); t++; end
        read_pixels(2400, 3, 2, 20000, tag);
      end
    join
    repeat (4) @(negedge PCK);
    chk({tag, ".ovf"}, bus.BUF_OVERFLOW, 0);
    chk({tag, ".unf"}, bus.BUF_UNDERFLOW, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    bus.DISPON = 1'b1;
    bus.DSP_preDE = 1'b0;
    bus.RVALID = 1'b0;
    bus.RREADY = 1'b0;
    bus.RDATA = '0;

    do_reset();

    // One burst, displayed back-to-back
    for (int w = 0; w < 32; w++) send_word(mkword(w), 1'b0, 1'b0);
    end_write();
    repeat (8) @(negedge PCK);
    for (int i = 0; i < 64; i++) add_vec(1'b1, 1'b1, 24'(i), 1'b0);
    add_vec(1'b0, 1'b0, 24'h0, 1'b0);
    run_vecs("burst");

    // Underflow on empty FIFO: black pixels, sticky flag
    add_vec(1'b1, 1'b1, 24'h0, 1'b1);
    add_vec(1'b1, 1'b1, 24'h0, 1'b1);
    add_vec(1'b0, 1'b0, 24'h0, 1'b1);
    add_vec(1'b0, 1'b0, 24'h0, 1'b1);
    run_vecs("unf");
    chk("unf.ovf", bus.BUF_OVERFLOW, 0);

    // Threshold at 480/481 words
    do_reset();
    for (int w = 0; w < 480; w++) send_word(mkword(w), 1'b0, 1'b0);
    end_write();
    chk("thr.wready480", bus.BUF_WREADY, 1);
    send_word(mkword(480), 1'b0, 1'b0);
    end_write();
    chk("thr.wready481", bus.BUF_WREADY, 0);
    repeat (6) @(negedge PCK);
    for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b1, 24'(i), 1'b0);
    add_vec(1'b0, 1'b0, 24'h0, 1'b0);
    run_vecs("thr");
    for (int k = 0; k < 4; k++) begin
      if (bus.BUF_WREADY) break;
      @(posedge ACLK); #1;
    end
    chk("thr.wready479", bus.BUF_WREADY, 1);

    // DISPON low: DE follows preDE with black and nothing is popped
    bus.DISPON = 1'b0;
    repeat (4) @(negedge PCK);
    add_vec(1'b1, 1'b1, 24'h0, 1'b0);
    add_vec(1'b1, 1'b1, 24'h0, 1'b0);
    add_vec(1'b0, 1'b0, 24'h0, 1'b0);
    run_vecs("dispoff");
    bus.DISPON = 1'b1;
    repeat (4) @(negedge PCK);
    add_vec(1'b1, 1'b1, 24'd4, 1'b0);
    add_vec(1'b1, 1'b1, 24'd5, 1'b0);
    add_vec(1'b0, 1'b0, 24'h0, 1'b0);
    run_vecs("dispon");

    // Overflow: 512 words fill, the 513th is dropped
    do_reset();
    for (int w = 0; w < 512; w++) send_word(mkword(w), 1'b0, 1'b1);
    end_write();
    chk("ovf.before", bus.BUF_OVERFLOW, 0);
    chk("ovf.wready_full", bus.BUF_WREADY, 0);
    send_word(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);
    end_write();
    chk("ovf.set", bus.BUF_OVERFLOW, 1);
    repeat (4) @(negedge PCK);
    read_pixels(1024, 1, 0, 2000, "ovf");
    chk("ovf.sticky", bus.BUF_OVERFLOW, 1);
    chk("ovf.unf", bus.BUF_UNDERFLOW, 0);
    chk("ovf.q_left", exp_q.size(), 0);

    // Long streams with blanking across two clock ratios
    stream(5, 20, 1'b1, "s4to1");
    stream(15, 5, 1'b0, "s1to3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
